// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one byte-addressed data memory between the
// core LSU (port 0) and the DMA/debug loader (port 1). One access in flight:
// IDLE accepts a request, ACCESS drives the memory, RESP returns the result.
// Alignment and range are checked at accept time so a bad store never
// reaches MemRW.
module dmem_arbiter #(
  parameter int AWIDTH    = 32,
  parameter int DWIDTH    = 32,
  parameter int MEM_BYTES = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_we,
  input  logic [2:0]        req_size0,
  input  logic [2:0]        req_size1,
  input  logic [AWIDTH-1:0] req_addr0,
  input  logic [AWIDTH-1:0] req_addr1,
  input  logic [DWIDTH-1:0] req_wdata0,
  input  logic [DWIDTH-1:0] req_wdata1,
  output logic [1:0]        req_ready,
  output logic [1:0]        rsp_valid,
  output logic              rsp_err,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic [2:0]        mem_size,
  output logic              mem_memrw,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_dataw,
  input  logic [DWIDTH-1:0] mem_datar
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [AWIDTH:0] MEM_LIM = (AWIDTH+1)'(MEM_BYTES);

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic              g_q, g_d;
  logic              we_q, we_d;
  logic [2:0]        size_q, size_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [DWIDTH-1:0] rdata_q, rdata_d;

  logic              any_vld;
  logic              gnt;
  logic              sel_we;
  logic [2:0]        sel_size;
  logic [AWIDTH-1:0] sel_addr;
  logic [DWIDTH-1:0] sel_wdata;
  logic [AWIDTH:0]   span;
  logic [AWIDTH:0]   last_byte;
  logic              sel_err;

  assign any_vld   = |req_valid;
  // Contention goes to the port that did not win last time; otherwise the lone requester.
  assign gnt       = (req_valid == 2'b11) ? ~last_q : req_valid[1];
  assign sel_we    = req_we[gnt];
  assign sel_size  = gnt ? req_size1  : req_size0;
  assign sel_addr  = gnt ? req_addr1  : req_addr0;
  assign sel_wdata = gnt ? req_wdata1 : req_wdata0;

  // Alignment and range check of the request being offered this cycle.
  always_comb begin
    span = '0;
    case (sel_size[1:0])
      2'b00:   span = (AWIDTH+1)'(0);
      2'b01:   span = (AWIDTH+1)'(1);
      default: span = (AWIDTH+1)'(3);
    endcase
    // One extra bit keeps addresses near the top of the space from wrapping.
    last_byte = {1'b0, sel_addr} + span;
    sel_err   = (sel_size[1:0] == 2'b11)
              | ((sel_size[1:0] == 2'b01) & sel_addr[0])
              | ((sel_size[1:0] == 2'b10) & (|sel_addr[1:0]))
              | (last_byte >= MEM_LIM);
  end

  // Next-state, latching and output decode.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    g_d       = g_q;
    we_d      = we_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    rsp_err   = 1'b0;
    mem_size  = '0;
    mem_memrw = 1'b0;
    mem_addr  = '0;
    mem_dataw = '0;
    case (state_q)
      IDLE: begin
        if (any_vld) begin
          req_ready = gnt ? 2'b10 : 2'b01;
          g_d       = gnt;
          last_d    = gnt;
          we_d      = sel_we;
          size_d    = sel_size;
          addr_d    = sel_addr;
          wdata_d   = sel_wdata;
          err_d     = sel_err;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        mem_size  = size_q;
        mem_addr  = addr_q;
        mem_dataw = wdata_q;
        mem_memrw = we_q & ~err_q;
        // Reads refresh the data (zero on error); writes leave it alone.
        if (!we_q) rdata_d = err_q ? '0 : mem_datar;
        state_d   = RESP;
      end
      RESP: begin
        rsp_valid = g_q ? 2'b10 : 2'b01;
        rsp_err   = err_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_rdata = rdata_q;

  // State and latched-request registers; reset drops any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      g_q     <= 1'b0;
      we_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      g_q     <= g_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 512-byte memory model
// (synchronous write, combinational sign/zero-extending read).
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_we;
  logic [2:0]  req_size0, req_size1;
  logic [31:0] req_addr0, req_addr1;
  logic [31:0] req_wdata0, req_wdata1;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [2:0]  mem_size;
  logic        mem_memrw;
  logic [31:0] mem_addr;
  logic [31:0] mem_dataw;
  logic [31:0] mem_datar;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  dmem_arbiter #(.AWIDTH(32), .DWIDTH(32), .MEM_BYTES(512)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we),
    .req_size0(req_size0), .req_size1(req_size1),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_size(mem_size), .mem_memrw(mem_memrw),
    .mem_addr(mem_addr), .mem_dataw(mem_dataw),
    .mem_datar(mem_datar)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model.
  logic [7:0] mem [0:511];
  logic [8:0] a0, a1, a2, a3;
  assign a0 = mem_addr[8:0];
  assign a1 = a0 + 9'd1;
  assign a2 = a0 + 9'd2;
  assign a3 = a0 + 9'd3;

  always_comb begin
    mem_datar = {mem[a3], mem[a2], mem[a1], mem[a0]};
    case (mem_size)
      3'b000:  mem_datar = {{24{mem[a0][7]}}, mem[a0]};
      3'b001:  mem_datar = {{16{mem[a1][7]}}, mem[a1], mem[a0]};
      3'b100:  mem_datar = {24'h0, mem[a0]};
      3'b101:  mem_datar = {16'h0, mem[a1], mem[a0]};
      default: mem_datar = {mem[a3], mem[a2], mem[a1], mem[a0]};
    endcase
  end

  always @(posedge clk) begin
    if (mem_memrw) begin
      wr_cnt++;
      mem[a0] <= mem_dataw[7:0];
      if (mem_size[1:0] != 2'b00) mem[a1] <= mem_dataw[15:8];
      if (mem_size[1:0] == 2'b10) begin
        mem[a2] <= mem_dataw[23:16];
        mem[a3] <= mem_dataw[31:24];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One request on port p; returns response err/data after checking timing.
  task automatic xfer(input int p, input logic we, input logic [2:0] sz,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic err, output logic [31:0] rd);
    int cyc;
    @(negedge clk);
    if (p == 0) begin
      req_we[0] = we; req_size0 = sz; req_addr0 = a; req_wdata0 = d;
    end else begin
      req_we[1] = we; req_size1 = sz; req_addr1 = a; req_wdata1 = d;
    end
    req_valid[p] = 1'b1;
    cyc = 0;
    #1;
    while (!req_ready[p] && cyc < 20) begin
      @(negedge clk); #1; cyc++;
    end
    chk("ready_seen", 32'(cyc < 20), 32'd1);
    @(negedge clk);
    req_valid[p] = 1'b0;
    #1 chk("no_rsp_in_access", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    #1 chk("rsp_valid_pulse", 32'(rsp_valid), (p == 0) ? 32'd1 : 32'd2);
    err = rsp_err;
    rd  = rsp_rdata;
  endtask

  logic        e;
  logic [31:0] r;
  int          gcyc[$];
  int          gport[$];
  logic [1:0]  seen;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    rst_n = 1'b0;
    req_valid = 2'b00; req_we = 2'b00;
    req_size0 = 3'b0; req_size1 = 3'b0;
    req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_memrw", 32'(mem_memrw), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Store then load a word.
    xfer(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, e, r);
    chk("sw_err", 32'(e), 32'd0);
    xfer(0, 1'b0, 3'b010, 32'h10, 32'h0, e, r);
    chk("lw_err", 32'(e), 32'd0);
    chk("lw_data", r, 32'hDEADBEEF);

    // Misaligned half store must not touch memory.
    xfer(1, 1'b1, 3'b000, 32'h21, 32'h5A, e, r);
    chk("sb21_err", 32'(e), 32'd0);
    wr_cnt = 0;
    xfer(0, 1'b1, 3'b001, 32'h21, 32'h8001, e, r);
    chk("sh_mis_err", 32'(e), 32'd1);
    chk("sh_mis_nowrite", 32'(wr_cnt), 32'd0);
    xfer(0, 1'b0, 3'b100, 32'h21, 32'h0, e, r);
    chk("lbu21_data", r, 32'h5A);

    // Range limit.
    xfer(1, 1'b0, 3'b010, 32'h1FE, 32'h0, e, r);
    chk("lw1fe_err", 32'(e), 32'd1);
    chk("lw1fe_zero", r, 32'd0);
    xfer(1, 1'b1, 3'b010, 32'h1FC, 32'h12345678, e, r);
    chk("sw1fc_err", 32'(e), 32'd0);
    xfer(0, 1'b0, 3'b010, 32'h1FC, 32'h0, e, r);
    chk("lw1fc_err", 32'(e), 32'd0);
    chk("lw1fc_data", r, 32'h12345678);
    xfer(0, 1'b1, 3'b000, 32'h1FF, 32'h77, e, r);
    chk("sb1ff_err", 32'(e), 32'd0);
    xfer(0, 1'b0, 3'b100, 32'h1FF, 32'h0, e, r);
    chk("lbu1ff_data", r, 32'h77);
    xfer(0, 1'b0, 3'b100, 32'h200, 32'h0, e, r);
    chk("lb200_err", 32'(e), 32'd1);
    xfer(0, 1'b0, 3'b011, 32'h0, 32'h0, e, r);
    chk("dword_err", 32'(e), 32'd1);
    xfer(1, 1'b0, 3'b010, 32'h12, 32'h0, e, r);
    chk("lw_mis_err", 32'(e), 32'd1);

    // Sign/zero extension.
    xfer(0, 1'b1, 3'b000, 32'h30, 32'h80, e, r);
    xfer(0, 1'b0, 3'b000, 32'h30, 32'h0, e, r);
    chk("lb_signed", r, 32'hFFFFFF80);
    xfer(1, 1'b0, 3'b100, 32'h30, 32'h0, e, r);
    chk("lbu_zero", r, 32'h00000080);
    xfer(1, 1'b1, 3'b010, 32'h60, 32'h11111111, e, r);
    chk("rdata_hold_on_wr", r, 32'h00000080);
    xfer(1, 1'b1, 3'b001, 32'h40, 32'hBEEF, e, r);
    xfer(0, 1'b0, 3'b001, 32'h40, 32'h0, e, r);
    chk("lh_signed", r, 32'hFFFFBEEF);
    xfer(0, 1'b0, 3'b101, 32'h40, 32'h0, e, r);
    chk("lhu_zero", r, 32'h0000BEEF);

    // Both ports valid from reset: strict alternation, 3 cycles apart.
    @(negedge clk);
    rst_n = 1'b0;
    req_we = 2'b00; req_size0 = 3'b010; req_size1 = 3'b010;
    req_addr0 = 32'h10; req_addr1 = 32'h1FC;
    req_valid = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (req_ready != 2'b00) begin
        gcyc.push_back(c);
        gport.push_back(req_ready[1] ? 1 : 0);
      end
      @(negedge clk);
    end
    chk("arb_grants", 32'(gcyc.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < gcyc.size()) begin
        chk("arb_port", 32'(gport[i]), 32'(i % 2));
        chk("arb_cycle", 32'(gcyc[i]), 32'(3 * i));
      end
    end
    req_valid = 2'b00;
    repeat (4) @(negedge clk);

    // Reset during the ACCESS cycle of a store.
    req_we[0] = 1'b1; req_size0 = 3'b010; req_addr0 = 32'h50; req_wdata0 = 32'hCAFEF00D;
    req_valid = 2'b01;
    #1 chk("mid_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    #1 chk("mid_memrw_hi", 32'(mem_memrw), 32'd1);
    chk("mid_mem_addr", mem_addr, 32'h50);
    #1 rst_n = 1'b0;
    #1 chk("mid_memrw_async", 32'(mem_memrw), 32'd0);
    req_we = 2'b00; req_addr0 = 32'h50; req_addr1 = 32'h50;
    req_valid = 2'b11;
    seen = 2'b00;
    repeat (3) begin
      @(negedge clk); #1 seen = seen | rsp_valid;
    end
    chk("mid_no_rsp", 32'(seen), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_grant0", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    #1 chk("post_rst_rsp", 32'(rsp_valid), 32'd1);
    chk("post_rst_nowrite", rsp_rdata, 32'd0);
    chk("post_rst_err", 32'(rsp_err), 32'd0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
